// File: rtl/scan_pkg.sv
// Shared types and the scan operator used by scan_engine.
// Operands are sign-extended to MAX_W so that one function serves every element width.
package scan_pkg;

    localparam int MAX_W = 128;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        MIN = 2'd1,
        MAX = 2'd2,
        XOR = 2'd3
    } scan_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CALC,
        WR,
        DONE
    } scan_state_e;

    // The value occupies the low MAX_W bits, so a size cast of the whole struct yields the value.
    typedef struct packed {
        logic             sat;
        logic [MAX_W-1:0] value;
    } op_res_t;

    // w is the real element width; it sets the saturation limits for add.
    function automatic op_res_t op(input scan_mode_e mode,
                                   input logic signed [MAX_W-1:0] a,
                                   input logic signed [MAX_W-1:0] b,
                                   input int w,
                                   input logic satEn);
        logic signed [MAX_W-1:0] one;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        logic signed [MAX_W-1:0] sum;
        op_res_t res;
        one = 1;
        hi  = (one <<< (w - 1)) - one;
        lo  = -(one <<< (w - 1));
        sum = a + b;
        res.sat   = 1'b0;
        res.value = sum;
        case (mode)
            ADD: begin
                if (satEn && (sum > hi)) begin
                    res.value = hi;
                    res.sat   = 1'b1;
                end else if (satEn && (sum < lo)) begin
                    res.value = lo;
                    res.sat   = 1'b1;
                end
            end
            MIN:     res.value = (a < b) ? a : b;
            MAX:     res.value = (a > b) ? a : b;
            default: res.value = a ^ b;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/scan_engine_if.sv
// Host-side bus of scan_engine: run control, status and the shared memory port.
interface scan_engine_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
);
    logic              r_enable;
    logic [1:0]        mode;
    logic [DATA_W-1:0] init_acc;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   length;
    logic              w_enable;
    logic              busy;
    logic [DATA_W-1:0] result;
    logic              ovf;
    logic              controlArr;
    logic              controlArrWEnable_a;
    logic [ADDR_W-1:0] controlArrAddr_a;
    logic [DATA_W-1:0] controlArrWData_a;
    logic [DATA_W-1:0] controlArrRData_a;

    modport master (
        output r_enable, mode, init_acc, start_addr, length,
        output controlArr, controlArrWEnable_a, controlArrAddr_a, controlArrWData_a,
        input  w_enable, busy, result, ovf, controlArrRData_a
    );

    modport slave (
        input  r_enable, mode, init_acc, start_addr, length,
        input  controlArr, controlArrWEnable_a, controlArrAddr_a, controlArrWData_a,
        output w_enable, busy, result, ovf, controlArrRData_a
    );
endinterface

// File: rtl/scan_ram.sv
// Single-port synchronous RAM with a registered read; contents are never reset.
module scan_ram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/scan_engine.sv
// In-place inclusive-scan engine: FSM, host/engine port mux and accumulator around scan_ram.
// Define SCAN_SAT_EN to make add saturate and to drive the sticky ovf flag.
module scan_engine
    import scan_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input logic          clk,
    input logic          rst,
    scan_engine_if.slave bus
);
`ifdef SCAN_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    scan_state_e       r_state;
    scan_state_e       w_nextState;
    scan_mode_e        r_mode;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] w_accNext;
    logic [ADDR_W-1:0] r_start;
    logic [ADDR_W-1:0] w_engAddr;
    logic [ADDR_W-1:0] w_memAddr;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_k;
    logic [ADDR_W:0]   w_lenEff;
    logic              w_start;
    logic              w_busy;
    logic              w_done;
    logic              w_memWe;
    logic [DATA_W-1:0] w_memWData;
    logic [DATA_W-1:0] w_memRData;
    op_res_t           w_opRes;

    assign w_lenEff  = (bus.length > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : bus.length;
    assign w_start   = (r_state == IDLE) && bus.r_enable && !bus.controlArr;
    assign w_engAddr = r_start + r_k[ADDR_W-1:0];

    assign w_opRes   = op(r_mode,
                          {{(MAX_W-DATA_W){r_acc[DATA_W-1]}}, r_acc},
                          {{(MAX_W-DATA_W){w_memRData[DATA_W-1]}}, w_memRData},
                          DATA_W, SAT_EN);
    assign w_accNext = DATA_W'(w_opRes);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_nextState = (w_lenEff == '0) ? DONE : RD;
                end
            end
            RD:      w_nextState = CALC;
            CALC:    w_nextState = WR;
            WR:      w_nextState = ((r_k + 1'b1) == r_len) ? DONE : RD;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // The host only gets the memory port while the engine is not mid-scan.
    always_comb begin
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_memWe    = 1'b0;
        w_memAddr  = w_engAddr;
        w_memWData = r_acc;
        case (r_state)
            RD, CALC: w_busy = 1'b1;
            WR: begin
                w_busy  = 1'b1;
                w_memWe = 1'b1;
            end
            DONE:    w_done = 1'b1;
            default: ;
        endcase
        if (bus.controlArr && !w_busy) begin
            w_memAddr  = bus.controlArrAddr_a;
            w_memWe    = bus.controlArrWEnable_a;
            w_memWData = bus.controlArrWData_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode   <= ADD;
            r_acc    <= '0;
            r_start  <= '0;
            r_len    <= '0;
            r_k      <= '0;
            r_result <= '0;
        end else begin
            if (w_start) begin
                r_mode  <= scan_mode_e'(bus.mode);
                r_acc   <= bus.init_acc;
                r_start <= bus.start_addr;
                r_len   <= w_lenEff;
                r_k     <= '0;
            end
            if (r_state == CALC) begin
                r_acc <= w_accNext;
            end
            if (r_state == WR) begin
                r_k <= r_k + 1'b1;
            end
            // A zero-length run reaches DONE straight from IDLE, before r_acc holds init_acc.
            if (w_nextState == DONE) begin
                r_result <= (r_state == IDLE) ? bus.init_acc : r_acc;
            end
        end
    end

`ifdef SCAN_SAT_EN
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_start) begin
            r_ovf <= 1'b0;
        end else if ((r_state == CALC) && w_opRes.sat) begin
            r_ovf <= 1'b1;
        end
    end

    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.busy              = w_busy;
    assign bus.w_enable          = w_done;
    assign bus.result            = r_result;
    assign bus.controlArrRData_a = w_memRData;

    scan_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_memWe),
        .i_addr  (w_memAddr),
        .i_wdata (w_memWData),
        .o_rdata (w_memRData)
    );
endmodule
